// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the multi-channel sigma-delta PDM DAC.
package pdm_pkg;

    typedef enum int unsigned {
        PDM_ORDER1 = 1,
        PDM_ORDER2 = 2
    } pdm_order_e;

    function automatic int unsigned int1_width(input int unsigned w);
        return w + 2;
    endfunction

    function automatic int unsigned int2_width(input int unsigned w);
        return w + 4;
    endfunction

    // Clamp a 32-bit signed value into the range of a w-bit signed integrator.
    function automatic logic signed [31:0] sat_w(input logic signed [31:0] v, input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pdm_mod.sv
// One-channel sigma-delta PDM modulator (first or second order); steps only when en is high.
module pdm_mod
    import pdm_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned ORDER = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] x,
    output logic                out
);

    localparam int unsigned IW = (ORDER == PDM_ORDER2) ? int2_width(W) : int1_width(W);
    localparam logic signed [31:0] FS = 32'sd1 <<< (W - 1);

    logic signed [IW-1:0] i1_q;
    logic signed [IW-1:0] i1_d;
    logic signed [IW-1:0] i2_q;
    logic signed [IW-1:0] i2_d;
    logic                 out_q;
    logic                 out_d;
    logic signed [31:0]   fb;
    logic signed [31:0]   s1;
    logic signed [31:0]   s2;

    // Integrator update; feedback is the previously emitted bit at full scale.
    always_comb begin
        i1_d  = i1_q;
        i2_d  = i2_q;
        out_d = out_q;
        fb    = out_q ? FS : -FS;
        s1    = 32'(i1_q) + 32'(x) - fb;
        s2    = 32'(i2_q);
        if (ORDER == PDM_ORDER2) begin
            s1 = sat_w(s1, IW);
            s2 = sat_w(32'(i2_q) + s1 - fb, IW);
        end
        if (en) begin
            i1_d = IW'(s1);
            if (ORDER == PDM_ORDER2) begin
                i2_d  = IW'(s2);
                out_d = !s2[31];
            end else begin
                out_d = !s1[31];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i1_q  <= '0;
            i2_q  <= '0;
            out_q <= 1'b0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/axis_pdm_dac_mc.sv
// Multi-channel AXI-Stream PDM DAC: frame ingest into a shadow buffer, commit to all
// channels on the sample tick, one sigma-delta modulator per channel.
module axis_pdm_dac_mc
    import pdm_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned W       = 16,
    parameter int unsigned ORDER   = 1,
    parameter int unsigned PDM_DIV = 16,
    parameter int unsigned OSR     = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   s_axis_tdata,
    input  logic           s_axis_tvalid,
    output logic           s_axis_tready,
    input  logic           s_axis_tlast,
    output logic [NCH-1:0] dac_out,
    output logic           underrun,
    output logic           frame_err
);

    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned DIV_W = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;
    localparam int unsigned OSR_W = $clog2(OSR);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PDM_DIV - 1);
    localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);

    logic [CH_W-1:0]     ch_q;
    logic [CH_W-1:0]     ch_d;
    logic                pend_q;
    logic                pend_d;
    logic                tready_q;
    logic                tready_d;
    logic                underrun_q;
    logic                underrun_d;
    logic                frame_err_q;
    logic                frame_err_d;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    div_d;
    logic [OSR_W-1:0]    osr_q;
    logic [OSR_W-1:0]    osr_d;
    logic signed [W-1:0] shadow_q [NCH];
    logic signed [W-1:0] shadow_d [NCH];
    logic signed [W-1:0] active_q [NCH];
    logic signed [W-1:0] active_d [NCH];

    logic pdm_tick_c;
    logic sample_tick_c;
    logic beat_c;
    logic ch_last_c;

    always_comb begin
        ch_d          = ch_q;
        pend_d        = pend_q;
        div_d         = div_q;
        osr_d         = osr_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        underrun_d    = 1'b0;
        frame_err_d   = 1'b0;
        pdm_tick_c    = (div_q == DIV_LAST);
        sample_tick_c = pdm_tick_c && (osr_q == OSR_LAST);
        beat_c        = s_axis_tvalid && tready_q;
        ch_last_c     = (ch_q == CH_LAST);

        div_d = pdm_tick_c ? '0 : div_q + DIV_W'(1);
        if (pdm_tick_c) begin
            osr_d = (osr_q == OSR_LAST) ? '0 : osr_q + OSR_W'(1);
        end

        // Commit sees the pend value from before any same-cycle tlast beat.
        if (sample_tick_c) begin
            if (pend_q) begin
                active_d = shadow_q;
                pend_d   = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (beat_c) begin
            shadow_d[ch_q] = s_axis_tdata;
            if (s_axis_tlast || ch_last_c) begin
                ch_d = '0;
                if (s_axis_tlast && ch_last_c) begin
                    pend_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                ch_d = ch_q + CH_W'(1);
            end
        end

        tready_d = !pend_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q        <= '0;
            pend_q      <= 1'b0;
            tready_q    <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            div_q       <= '0;
            osr_q       <= '0;
            shadow_q    <= '{default: '0};
            active_q    <= '{default: '0};
        end else begin
            ch_q        <= ch_d;
            pend_q      <= pend_d;
            tready_q    <= tready_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
            div_q       <= div_d;
            osr_q       <= osr_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pdm_mod #(
            .W     (W),
            .ORDER (ORDER)
        ) u_mod (
            .clk (clk),
            .rst (rst),
            .en  (pdm_tick_c),
            .x   (active_q[g]),
            .out (dac_out[g])
        );
    end

    assign s_axis_tready = tready_q;
    assign underrun      = underrun_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_axis_pdm_dac_mc.sv
// Directed bench for axis_pdm_dac_mc: a 2-channel first-order instance and a
// 4-channel second-order instance, both at one PDM bit per clk and OSR 64.
module tb_axis_pdm_dac_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] tdata;
    logic        tlast;
    logic        tvalid_a;
    logic        tvalid_b;
    logic        tready_a;
    logic        tready_b;
    logic [1:0]  dac_a;
    logic [3:0]  dac_b;
    logic        urun_a;
    logic        urun_b;
    logic        ferr_a;
    logic        ferr_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    axis_pdm_dac_mc #(.NCH(2), .W(16), .ORDER(1), .PDM_DIV(1), .OSR(64)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid_a),
        .s_axis_tready (tready_a),
        .s_axis_tlast  (tlast),
        .dac_out       (dac_a),
        .underrun      (urun_a),
        .frame_err     (ferr_a)
    );

    axis_pdm_dac_mc #(.NCH(4), .W(16), .ORDER(2), .PDM_DIV(1), .OSR(64)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid_b),
        .s_axis_tready (tready_b),
        .s_axis_tlast  (tlast),
        .dac_out       (dac_b),
        .underrun      (urun_b),
        .frame_err     (ferr_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int sel, input logic [15:0] d, input logic l);
        int guard;
        guard = 0;
        tdata = d;
        tlast = l;
        if (sel == 0) tvalid_a = 1'b1; else tvalid_b = 1'b1;
        while (((sel == 0) ? tready_a : tready_b) !== 1'b1 && guard < 500) begin
            step();
            guard++;
        end
        if (guard >= 500) begin
            n_cmp++; n_bad++;
            $display("FAIL send_beat timeout: tready low for %0d cycles, want high", guard);
        end
        step();
        tvalid_a = 1'b0;
        tvalid_b = 1'b0;
        tlast    = 1'b0;
    endtask

    task automatic wait_ready(input int sel);
        int guard;
        guard = 0;
        while (((sel == 0) ? tready_a : tready_b) !== 1'b1 && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_ready timeout: tready low for %0d cycles, want high", guard);
        end
    endtask

    task automatic measure(input int sel, output int o0, output int o1, output int ur);
        o0 = 0; o1 = 0; ur = 0;
        repeat (64) begin
            step();
            if (sel == 0) begin
                o0 += int'(dac_a[0]); o1 += int'(dac_a[1]); ur += int'(urun_a);
            end else begin
                o0 += int'(dac_b[0]); o1 += int'(dac_b[1]); ur += int'(urun_b);
            end
        end
    endtask

    task automatic test_reset();
        int cnt;
        bit seen;
        rst = 1'b1; tvalid_a = 1'b0; tvalid_b = 1'b0; tlast = 1'b0; tdata = '0;
        repeat (3) step();
        n_cmp++;
        if ({tready_a, dac_a, urun_a, ferr_a} !== 5'b0) begin
            n_bad++; $display("FAIL reset_a outputs: got %b want 00000", {tready_a, dac_a, urun_a, ferr_a});
        end
        n_cmp++;
        if ({tready_b, dac_b, urun_b, ferr_b} !== 7'b0) begin
            n_bad++; $display("FAIL reset_b outputs: got %b want 0000000", {tready_b, dac_b, urun_b, ferr_b});
        end
        rst = 1'b0;
        cnt = 0; seen = 0;
        while (!seen && cnt < 100) begin
            step();
            cnt++;
            if (cnt == 1) begin
                n_cmp++;
                if (tready_a !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", tready_a); end
            end
            if (urun_a === 1'b1) seen = 1;
        end
        n_cmp++;
        if (cnt != 64) begin n_bad++; $display("FAIL first_underrun cycle: got %0d want 64", cnt); end
        step();
        n_cmp++;
        if (urun_a !== 1'b0) begin n_bad++; $display("FAIL underrun_width: got %b want 0", urun_a); end
    endtask

    task automatic test_zero();
        int o0, o1, ur;
        send_beat(0, 16'h0000, 1'b0);
        send_beat(0, 16'h0000, 1'b1);
        wait_ready(0);
        measure(0, o0, o1, ur);
        n_cmp++;
        if (o0 < 31 || o0 > 33) begin n_bad++; $display("FAIL zero_ch0 density: got %0d want 32+-1", o0); end
        n_cmp++;
        if (o1 < 31 || o1 > 33) begin n_bad++; $display("FAIL zero_ch1 density: got %0d want 32+-1", o1); end
        n_cmp++;
        if (ur != 1) begin n_bad++; $display("FAIL zero_underrun count: got %0d want 1", ur); end
    endtask

    task automatic test_back_to_back();
        int o0, o1, ur;
        send_beat(0, 16'h4000, 1'b0);
        send_beat(0, 16'hC000, 1'b1);
        n_cmp++;
        if (tready_a !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_f1: got %b want 0", tready_a); end
        wait_ready(0);
        fork
            measure(0, o0, o1, ur);
            begin
                send_beat(0, 16'hC000, 1'b0);
                send_beat(0, 16'h4000, 1'b1);
                n_cmp++;
                if (tready_a !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_f2: got %b want 0", tready_a); end
            end
        join
        n_cmp++;
        if (o0 < 47 || o0 > 49) begin n_bad++; $display("FAIL b2b_f1_ch0 density: got %0d want 48+-1", o0); end
        n_cmp++;
        if (o1 < 15 || o1 > 17) begin n_bad++; $display("FAIL b2b_f1_ch1 density: got %0d want 16+-1", o1); end
        n_cmp++;
        if (ur != 0) begin n_bad++; $display("FAIL b2b_f1_underrun count: got %0d want 0", ur); end
        wait_ready(0);
        measure(0, o0, o1, ur);
        n_cmp++;
        if (o0 < 15 || o0 > 17) begin n_bad++; $display("FAIL b2b_f2_ch0 density: got %0d want 16+-1", o0); end
        n_cmp++;
        if (o1 < 47 || o1 > 49) begin n_bad++; $display("FAIL b2b_f2_ch1 density: got %0d want 48+-1", o1); end
        n_cmp++;
        if (ur != 1) begin n_bad++; $display("FAIL b2b_f2_underrun count: got %0d want 1", ur); end
    endtask

    task automatic test_underrun_hold();
        int o0, o1, ur;
        measure(0, o0, o1, ur);
        n_cmp++;
        if (o0 < 15 || o0 > 17) begin n_bad++; $display("FAIL hold_ch0 density: got %0d want 16+-1", o0); end
        n_cmp++;
        if (o1 < 47 || o1 > 49) begin n_bad++; $display("FAIL hold_ch1 density: got %0d want 48+-1", o1); end
        n_cmp++;
        if (ur != 1) begin n_bad++; $display("FAIL hold_underrun count: got %0d want 1", ur); end
    endtask

    task automatic test_mid_reset();
        int o0, o1, ur;
        send_beat(0, 16'h4000, 1'b0);
        rst = 1'b1;
        step();
        n_cmp++;
        if ({tready_a, dac_a, urun_a, ferr_a} !== 5'b0) begin
            n_bad++; $display("FAIL midreset outputs: got %b want 00000", {tready_a, dac_a, urun_a, ferr_a});
        end
        rst = 1'b0;
        send_beat(0, 16'hC000, 1'b0);
        n_cmp++;
        if (ferr_a !== 1'b0) begin n_bad++; $display("FAIL midreset_beat0 frame_err: got %b want 0", ferr_a); end
        send_beat(0, 16'h4000, 1'b1);
        n_cmp++;
        if (ferr_a !== 1'b0) begin n_bad++; $display("FAIL midreset_beat1 frame_err: got %b want 0", ferr_a); end
        wait_ready(0);
        measure(0, o0, o1, ur);
        n_cmp++;
        if (o0 < 15 || o0 > 17) begin n_bad++; $display("FAIL midreset_ch0 density: got %0d want 16+-1", o0); end
        n_cmp++;
        if (o1 < 47 || o1 > 49) begin n_bad++; $display("FAIL midreset_ch1 density: got %0d want 48+-1", o1); end
    endtask

    task automatic test_frame_err();
        int o0, o1, ur;
        wait_ready(1);
        send_beat(1, 16'h1111, 1'b0);
        send_beat(1, 16'h2222, 1'b0);
        n_cmp++;
        if (ferr_b !== 1'b0) begin n_bad++; $display("FAIL ferr_early: got %b want 0", ferr_b); end
        send_beat(1, 16'h3333, 1'b1);
        n_cmp++;
        if (ferr_b !== 1'b1) begin n_bad++; $display("FAIL ferr_short_frame: got %b want 1", ferr_b); end
        n_cmp++;
        if (tready_b !== 1'b1) begin n_bad++; $display("FAIL ferr_no_pend: tready got %b want 1", tready_b); end
        step();
        n_cmp++;
        if (ferr_b !== 1'b0) begin n_bad++; $display("FAIL ferr_width: got %b want 0", ferr_b); end
        for (int i = 0; i < 4; i++) send_beat(1, 16'h5555, 1'b0);
        n_cmp++;
        if (ferr_b !== 1'b1) begin n_bad++; $display("FAIL ferr_missing_tlast: got %b want 1", ferr_b); end
        send_beat(1, 16'h4000, 1'b0);
        send_beat(1, 16'hC000, 1'b0);
        send_beat(1, 16'h0000, 1'b0);
        send_beat(1, 16'h0000, 1'b1);
        n_cmp++;
        if ({ferr_b, tready_b} !== 2'b00) begin
            n_bad++; $display("FAIL good_frame ferr/tready: got %b want 00", {ferr_b, tready_b});
        end
        wait_ready(1);
        measure(1, o0, o1, ur);
        n_cmp++;
        if (o0 < 46 || o0 > 50) begin n_bad++; $display("FAIL ord2_ch0 density: got %0d want 48+-2", o0); end
        n_cmp++;
        if (o1 < 14 || o1 > 18) begin n_bad++; $display("FAIL ord2_ch1 density: got %0d want 16+-2", o1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero();
        test_back_to_back();
        test_underrun_hold();
        test_mid_reset();
        test_frame_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_pdm_dac_mc.md
# axis_pdm_dac_mc

Parametrised multi-channel successor to the single-channel 8-bit AXI-Stream PDM DAC. Accepts interleaved signed PCM frames on one AXI-Stream slave, double-buffers them and commits a full frame to all channels on a sample tick. Drives one sigma-delta PDM bit per channel at a programmable oversampled rate. Sits between the I2S receiver and the board PDM output pins.

## Interface
- `NCH`, 2: channel count, 1..8.
- `W`, 16: sample width, two's-complement, 8..24.
- `ORDER`, 1: modulator order, 1 or 2.
- `PDM_DIV`, 16: clk cycles per PDM bit, ≥1.
- `OSR`, 64: PDM bits per sample tick, ≥2.
- `clk`  in  1  system clock. One clock; all logic is on it.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  W  one channel sample.
- `s_axis_tvalid`  in  1  sample valid.
- `s_axis_tready`  out  1  block can accept.
- `s_axis_tlast`  in  1  marks channel NCH-1 of a frame.
- `dac_out`  out  NCH  PDM bit per channel, bit i = channel i.
- `underrun`  out  1  one-cycle pulse: tick with no pending frame.
- `frame_err`  out  1  one-cycle pulse: frame length mismatch, frame dropped.

## Operation
- Ingest: index `ch` counts beats 0..NCH-1; beat writes `shadow[ch]`. Beat accepted when tvalid&&tready.
- Frame check: tlast on ch==NCH-1 → `pend`=1, ch=0. tlast with ch<NCH-1, or no tlast at ch==NCH-1 → frame dropped, frame_err pulses, ch=0, pend unchanged; shadow contents are don't-care until the next good frame overwrites them.
- tready = !pend. One pending frame max; backpressure while pending.
- PDM tick: divider counts 0..PDM_DIV-1, tick on terminal count. Sample tick: every OSR-th PDM tick.
- On sample tick: if pend, `active[i]`←`shadow[i]` for all i, pend←0 (tready rises the next cycle); else underrun pulses, active held.
- Same-cycle tlast acceptance and sample tick: the tick sees old pend; the new frame becomes pending, committed at the next tick (no underrun if previous pend was 1).
- Modulator per channel, update on PDM tick only; y = dac_out[i]? +2^(W-1) : −2^(W-1).
  - ORDER=1: i1 (W+2 bits signed) += x − y; dac_out = (i1_next ≥ 0).
  - ORDER=2: i1 += x − y; i2 += i1_next − y (both W+4 bits signed, saturating at ±max); dac_out = (i2_next ≥ 0).
- Reset: ch=0, pend=0, active=0, integrators=0, dividers=0, dac_out=0, tready=0 during reset then 1, underrun=frame_err=0.

## Timing
- Accept-to-commit: frame committed at first sample tick after tlast beat; dac_out reflects new sample at the PDM tick after commit (≤ PDM_DIV·OSR + PDM_DIV clk).
- dac_out registered, changes only on PDM-tick cycles.
- Pulses underrun/frame_err registered, exactly one cycle, same cycle as the offending tick/beat +1.
- Reset mid-frame discards partial frame and pending frame; first sample tick after reset pulses underrun unless a full frame arrived.
- Full throughput: one beat/clk while !pend.

## Structure
- Package `pdm_pkg`: ORDER enum constants, integrator width functions (W+2, W+4), saturation helper.
- Sub-module `pdm_mod` (one channel modulator, parameters W, ORDER, ports clk, rst, en, x, out), instantiated NCH times via generate. Top holds ingest, shadow/active, dividers.

## Test plan
- NCH=2, W=16, ORDER=1, PDM_DIV=1, OSR=64: frame {0x0000,0x0000} → each channel's ones density over 64 bits = 32 ±1.
- Frame {0x4000 (+0.5 FS), 0xC000 (−0.5 FS)} → densities 48/64 and 16/64 ±1; ORDER=2 same ±2.
- Two frames back-to-back → tready drops after second tlast until next sample tick; no beats lost; commit order preserved.
- No frame for one tick → underrun one-cycle pulse, dac_out pattern continues from held sample.
- NCH=4, tlast on beat 2 → frame_err pulse, pend stays 0, next correct 4-beat frame commits normally.
- Assert rst mid-frame (after 1 beat) → all outputs at reset values next cycle; following full frame accepted from ch=0.
